regfile_wb_arbiter: RTL and testbench

- Owns the single write port of the integer register file.
- Arbitrates between two writeback sources:
  - port 0: the in-order ALU/load pipeline.
  - port 1: the long-latency mul/div unit, buffered in a small FIFO.
- Keeps a per-register pending scoreboard so decode can stall on operands still owned by the long-latency unit.
- Drives registered write_en/write_id/write_data straight into the register file.

---
 rtl/regfile_wb_arbiter_pkg.sv | 15 +
 rtl/regfile_wb_arbiter_fifo.sv | 53 +++++
 rtl/regfile_wb_arbiter.sv | 116 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

    localparam int REG_ADDR_WIDTH     = 5;
    localparam int DATA_WIDTH         = 32;
    localparam int REGISTER_FILE_SIZE = 2 ** REG_ADDR_WIDTH;

    typedef logic [REG_ADDR_WIDTH-1:0] reg_id_t;

    typedef struct packed {
        reg_id_t               id;
        logic [DATA_WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// Small synchronous FIFO of writeback requests buffering the long-latency unit.
module wb_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  wb_req_t                push_data,
    input  logic                   pop,
    output wb_req_t                head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_req_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push while full is only accepted alongside a pop, which frees the slot.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline vs. buffered mul/div results, plus pending scoreboard.
// Optional starvation guard for the mul/div path: define RF_WB_STARVE_GUARD_EN.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_REGS       = 32,
    parameter int FIFO_DEPTH     = 2,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      p0_valid,
    output logic                      p0_ready,
    input  logic [REG_ADDR_WIDTH-1:0] p0_id,
    input  logic [DATA_WIDTH-1:0]     p0_data,
    input  logic                      p1_valid,
    output logic                      p1_ready,
    input  logic [REG_ADDR_WIDTH-1:0] p1_id,
    input  logic [DATA_WIDTH-1:0]     p1_data,
    input  logic                      sb_set_valid,
    input  logic [REG_ADDR_WIDTH-1:0] sb_set_id,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_id,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_id,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    output logic                      wb_write_en,
    output logic [REG_ADDR_WIDTH-1:0] wb_write_id,
    output logic [DATA_WIDTH-1:0]     wb_write_data
);

    import regfile_wb_arbiter_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    wb_req_t            fifo_in;
    wb_req_t            fifo_head;
    logic               fifo_empty;
    logic               unused_fifo_full;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_push;
    logic               fifo_grant;
    logic               starve_grant;
    logic               p0_fire;
    logic [NUM_REGS-1:0] busy;

    assign p1_ready  = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign fifo_push = p1_valid && p1_ready;
    assign fifo_in   = '{id: p1_id, data: p1_data};

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_grant),
        .head      (fifo_head),
        .full      (unused_fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef RF_WB_STARVE_GUARD_EN
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    logic [SC_W-1:0] starve_cnt;

    assign starve_grant = !fifo_empty && (starve_cnt == SC_W'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (!reset_n || fifo_grant) starve_cnt <= '0;
        else if (!fifo_empty)       starve_cnt <= starve_cnt + 1'b1;
    end
`else
    logic unused_starve_limit;
    assign unused_starve_limit = ^STARVE_LIMIT;
    assign starve_grant        = 1'b0;
`endif

    assign p0_ready   = !starve_grant;
    assign p0_fire    = p0_valid && p0_ready;
    assign fifo_grant = !fifo_empty && (!p0_valid || starve_grant);

    // Register-0 writes are consumed here but never reach the register file.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wb_write_en   <= 1'b0;
            wb_write_id   <= '0;
            wb_write_data <= '0;
        end else if (p0_fire) begin
            wb_write_en   <= (p0_id != '0);
            wb_write_id   <= p0_id;
            wb_write_data <= p0_data;
        end else if (fifo_grant) begin
            wb_write_en   <= (fifo_head.id != '0);
            wb_write_id   <= fifo_head.id;
            wb_write_data <= fifo_head.data;
        end else begin
            wb_write_en   <= 1'b0;
        end
    end

    // Set is applied after clear so a same-cycle set of the popped id wins.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy <= '0;
        end else begin
            if (fifo_grant)                        busy[fifo_head.id] <= 1'b0;
            if (sb_set_valid && sb_set_id != '0)   busy[sb_set_id]    <= 1'b1;
        end
    end

    assign rs1_busy = (rs1_id != '0) && busy[rs1_id];
    assign rs2_busy = (rs2_id != '0) && busy[rs2_id];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (honours RF_WB_STARVE_GUARD_EN).
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        p0_valid, p0_ready;
    logic [4:0]  p0_id;
    logic [31:0] p0_data;
    logic        p1_valid, p1_ready;
    logic [4:0]  p1_id;
    logic [31:0] p1_data;
    logic        sb_set_valid;
    logic [4:0]  sb_set_id, rs1_id, rs2_id;
    logic        rs1_busy, rs2_busy;
    logic        wb_write_en;
    logic [4:0]  wb_write_id;
    logic [31:0] wb_write_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .DATA_WIDTH     (32),
        .REG_ADDR_WIDTH (5),
        .NUM_REGS       (32),
        .FIFO_DEPTH     (2),
        .STARVE_LIMIT   (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .p0_valid      (p0_valid),
        .p0_ready      (p0_ready),
        .p0_id         (p0_id),
        .p0_data       (p0_data),
        .p1_valid      (p1_valid),
        .p1_ready      (p1_ready),
        .p1_id         (p1_id),
        .p1_data       (p1_data),
        .sb_set_valid  (sb_set_valid),
        .sb_set_id     (sb_set_id),
        .rs1_id        (rs1_id),
        .rs2_id        (rs2_id),
        .rs1_busy      (rs1_busy),
        .rs2_busy      (rs2_busy),
        .wb_write_en   (wb_write_en),
        .wb_write_id   (wb_write_id),
        .wb_write_data (wb_write_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0; p0_valid = 1'b0; p0_id = '0; p0_data = '0;
        p1_valid = 1'b0; p1_id = '0; p1_data = '0;
        sb_set_valid = 1'b0; sb_set_id = '0; rs1_id = '0; rs2_id = '0;
        tick(); tick();
        reset_n = 1'b1;
        check("rst_en", wb_write_en, 1'b0);
        check("rst_id", wb_write_id, 5'd0);
        check("rst_data", wb_write_data, 32'd0);
        repeat (5) tick();
        check("idle_en", wb_write_en, 1'b0);
        check("idle_p0_ready", p0_ready, 1'b1);
        check("idle_p1_ready", p1_ready, 1'b1);
        check("idle_rs1", rs1_busy, 1'b0);
        check("idle_rs2", rs2_busy, 1'b0);

        // pipeline write
        p0_valid = 1'b1; p0_id = 5'd3; p0_data = 32'hDEADBEEF;
        #1 check("p0_ready", p0_ready, 1'b1);
        tick();
        p0_valid = 1'b0;
        check("p0_en", wb_write_en, 1'b1);
        check("p0_id", wb_write_id, 5'd3);
        check("p0_data", wb_write_data, 32'hDEADBEEF);
        tick();
        check("hold_en", wb_write_en, 1'b0);
        check("hold_id", wb_write_id, 5'd3);
        check("hold_data", wb_write_data, 32'hDEADBEEF);

        // scoreboard set then long-latency result for r7
        sb_set_valid = 1'b1; sb_set_id = 5'd7; rs1_id = 5'd7;
        tick();
        sb_set_valid = 1'b0;
        check("sb7_set", rs1_busy, 1'b1);
        tick(); tick();
        check("sb7_held", rs1_busy, 1'b1);
        p1_valid = 1'b1; p1_id = 5'd7; p1_data = 32'h12345678;
        #1 check("p1_ready_push", p1_ready, 1'b1);
        tick();
        p1_valid = 1'b0;
        check("sb7_pop_cycle", rs1_busy, 1'b1);
        check("pre_pop_en", wb_write_en, 1'b0);
        tick();
        check("p1_en", wb_write_en, 1'b1);
        check("p1_id", wb_write_id, 5'd7);
        check("p1_data", wb_write_data, 32'h12345678);
        check("sb7_clear", rs1_busy, 1'b0);

        // fill FIFO while port 0 hogs the write port
        p0_valid = 1'b1; p0_id = 5'd9; p0_data = 32'hA0;
        p1_valid = 1'b1; p1_id = 5'd10; p1_data = 32'h111;
        tick();
        p1_id = 5'd11; p1_data = 32'h222;
        tick();
        p1_valid = 1'b0;
        check("full_p1_ready", p1_ready, 1'b0);
        check("full_p0_ready", p0_ready, 1'b1);
        tick();
        check("wait1_p0_ready", p0_ready, 1'b1);
        check("wait1_id", wb_write_id, 5'd9);
        check("wait1_en", wb_write_en, 1'b1);
        tick();
        check("wait2_p0_ready", p0_ready, 1'b1);
        tick();
`ifdef RF_WB_STARVE_GUARD_EN
        check("starve_p0_ready", p0_ready, 1'b0);
        tick();
        check("starve_id", wb_write_id, 5'd10);
        check("starve_data", wb_write_data, 32'h111);
        check("starve_en", wb_write_en, 1'b1);
        check("after_starve_p0_ready", p0_ready, 1'b1);
        check("after_starve_p1_ready", p1_ready, 1'b1);
        p0_valid = 1'b0;
        tick();
        check("drain_id", wb_write_id, 5'd11);
        check("drain_data", wb_write_data, 32'h222);
        check("drain_en", wb_write_en, 1'b1);
`else
        check("strict_p0_ready", p0_ready, 1'b1);
        tick();
        check("strict_id", wb_write_id, 5'd9);
        check("strict_p1_ready", p1_ready, 1'b0);
        p0_valid = 1'b0;
        tick();
        check("drain0_id", wb_write_id, 5'd10);
        check("drain0_data", wb_write_data, 32'h111);
        tick();
        check("drain1_id", wb_write_id, 5'd11);
        check("drain1_data", wb_write_data, 32'h222);
        check("drain1_en", wb_write_en, 1'b1);
`endif
        tick();
        check("drained_en", wb_write_en, 1'b0);
        check("drained_p1_ready", p1_ready, 1'b1);

        // register 0 write and scoreboard set
        p0_valid = 1'b1; p0_id = 5'd0; p0_data = 32'hFFFFFFFF;
        #1 check("r0_p0_ready", p0_ready, 1'b1);
        tick();
        p0_valid = 1'b0;
        check("r0_en", wb_write_en, 1'b0);
        sb_set_valid = 1'b1; sb_set_id = 5'd0; rs1_id = 5'd0;
        tick();
        sb_set_valid = 1'b0;
        check("r0_busy", rs1_busy, 1'b0);

        // reset with one buffered result and busy[5] set
        p0_valid = 1'b1; p0_id = 5'd1; p0_data = 32'h1;
        p1_valid = 1'b1; p1_id = 5'd5; p1_data = 32'h55;
        sb_set_valid = 1'b1; sb_set_id = 5'd5; rs2_id = 5'd5;
        tick();
        p0_valid = 1'b0; p1_valid = 1'b0; sb_set_valid = 1'b0;
        reset_n = 1'b0;
        #1 check("pre_rst_busy5", rs2_busy, 1'b1);
        tick();
        reset_n = 1'b1;
        check("mid_rst_en", wb_write_en, 1'b0);
        check("mid_rst_id", wb_write_id, 5'd0);
        check("mid_rst_data", wb_write_data, 32'd0);
        check("mid_rst_busy5", rs2_busy, 1'b0);
        tick();
        check("post_rst_en1", wb_write_en, 1'b0);
        tick();
        check("post_rst_en2", wb_write_en, 1'b0);
        check("post_rst_p1_ready", p1_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
